// File: rtl/bit_count_scheduler.sv
// Round-robin arbiter sharing one bit_counter among NUM_REQ requesters; grant -> LOAD -> RUN -> DRAIN -> IDLE.
// Optional RUN watchdog enabled by defining BIT_SCHED_TIMEOUT_EN (times out after TIMEOUT_CYCLES, acks with err=1).
module bit_count_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [3:0]           result,
    output logic [ID_W-1:0]      resp_id,
    output logic                 err,
    output logic                 busy,
    output logic                 cnt_start,
    output logic [7:0]           cnt_in,
    input  logic                 cnt_done,
    input  logic [3:0]           cnt_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ID_W-1:0]    last;
    logic [ID_W-1:0]    last_nxt;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    gnt_id_nxt;
    logic [ID_W-1:0]    pick_id;
    logic               pick_vld;
    logic [7:0]         pick_op;
    logic               tmo_hit;

    logic [NUM_REQ-1:0] ack_nxt;
    logic [3:0]         result_nxt;
    logic [ID_W-1:0]    resp_id_nxt;
    logic               err_nxt;
    logic               busy_nxt;
    logic               cnt_start_nxt;
    logic [7:0]         cnt_in_nxt;

    // First requester at or after last+1, wrapping; lower offsets win.
    always_comb begin
        logic [ID_W-1:0] cand;
        pick_vld = 1'b0;
        pick_id  = last;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last) + i) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    always_comb begin
        pick_op = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                pick_op = req_data[i*8 +: 8];
            end
        end
    end

`ifdef BIT_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Cleared while in LOAD so the count starts at zero on RUN entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == RUN) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == RUN) && !cnt_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (pick_vld) state_nxt = LOAD;
            LOAD:  state_nxt = RUN;
            RUN:   if (cnt_done || tmo_hit) state_nxt = DRAIN;
            DRAIN: if (!cnt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last_nxt      = last;
        gnt_id_nxt    = gnt_id;
        cnt_in_nxt    = cnt_in;
        cnt_start_nxt = 1'b0;
        ack_nxt       = '0;
        result_nxt    = result;
        resp_id_nxt   = resp_id;
        err_nxt       = 1'b0;
        busy_nxt      = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_id_nxt = pick_id;
                    last_nxt   = pick_id;
                    cnt_in_nxt = pick_op;
                end
            end
            LOAD: begin
                cnt_start_nxt = 1'b1;
            end
            RUN: begin
                if (cnt_done) begin
                    ack_nxt     = NUM_REQ'(1) << gnt_id;
                    result_nxt  = cnt_result;
                    resp_id_nxt = gnt_id;
                end else if (tmo_hit) begin
                    ack_nxt     = NUM_REQ'(1) << gnt_id;
                    result_nxt  = 4'd0;
                    resp_id_nxt = gnt_id;
                    err_nxt     = 1'b1;
                end else begin
                    cnt_start_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last      <= ID_W'(NUM_REQ - 1);
            gnt_id    <= '0;
            cnt_in    <= 8'h00;
            cnt_start <= 1'b0;
            ack       <= '0;
            result    <= 4'd0;
            resp_id   <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            last      <= last_nxt;
            gnt_id    <= gnt_id_nxt;
            cnt_in    <= cnt_in_nxt;
            cnt_start <= cnt_start_nxt;
            ack       <= ack_nxt;
            result    <= result_nxt;
            resp_id   <= resp_id_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_bit_count_scheduler.sv
// Scoreboard bench for bit_count_scheduler with a behavioural bit_counter model on the cnt_* side.
module tb_bit_count_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int LAT     = 3;
    localparam int TMO     = 32;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [3:0]           result;
    logic [ID_W-1:0]      resp_id;
    logic                 err;
    logic                 busy;
    logic                 cnt_start;
    logic [7:0]           cnt_in;
    logic                 cnt_done;
    logic [3:0]           cnt_result;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      res;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   ack_count  = 0;
    int   hold_left  = 0;
    bit   stub_hang  = 1'b0;

    always #5 clk = ~clk;

    bit_count_scheduler #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .result(result),
        .resp_id(resp_id),
        .err(err),
        .busy(busy),
        .cnt_start(cnt_start),
        .cnt_in(cnt_in),
        .cnt_done(cnt_done),
        .cnt_result(cnt_result)
    );

    // bit_counter stand-in: captures cnt_in while idle, reports after LAT cycles, holds done until start drops.
    logic [1:0] ph;
    logic [7:0] cap;
    int         cdown;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph <= 2'd0; cap <= 8'h00; cdown <= 0; cnt_done <= 1'b0; cnt_result <= 4'd0;
        end else begin
            case (ph)
                2'd0: begin
                    cap <= cnt_in;
                    if (cnt_start) begin ph <= 2'd1; cdown <= LAT; end
                end
                2'd1: begin
                    if (!cnt_start) ph <= 2'd0;
                    else if (cdown <= 1) begin
                        if (!stub_hang) begin
                            cnt_done <= 1'b1; cnt_result <= 4'($countones(cap)); ph <= 2'd2;
                        end
                    end else cdown <= cdown - 1;
                end
                default: if (!cnt_start) begin cnt_done <= 1'b0; ph <= 2'd0; end
            endcase
        end
    end

    function automatic exp_t mk(input int id, input int res, input bit e);
        exp_t x;
        x.id = ID_W'(id); x.res = 4'(res); x.err = e;
        return x;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0; req = '0; sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        bit done_ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin done_ok = 1'b1; break; end
        end
        compared++;
        if (!done_ok) begin
            mismatched++;
            $display("FAIL %s_timeout: pending=%0d busy=%0b, required pending=0 busy=0", name, sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; req_data = '0;
        repeat (2) @(negedge clk);
        compared++; if (ack !== '0)       begin mismatched++; $display("FAIL reset_ack: got %b want 0", ack); end
        compared++; if (result !== 4'd0)  begin mismatched++; $display("FAIL reset_result: got %0d want 0", result); end
        compared++; if (resp_id !== '0)   begin mismatched++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
        compared++; if (err !== 1'b0)     begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
        compared++; if (busy !== 1'b0)    begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (cnt_start !== 1'b0) begin mismatched++; $display("FAIL reset_cnt_start: got %b want 0", cnt_start); end
        compared++; if (cnt_in !== 8'h00) begin mismatched++; $display("FAIL reset_cnt_in: got %h want 00", cnt_in); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_job();
        int base;
        apply_reset();
        base = ack_count;
        req_data = '0; req_data[7:0] = 8'h16;
        sb.push_back(mk(0, 3, 1'b0));
        req = 4'b0001;
        wait_drain("single", 100);
        compared++; if (ack_count - base !== 1) begin mismatched++; $display("FAIL single_ack_count: got %0d want 1", ack_count - base); end
        repeat (3) @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        int base;
        apply_reset();
        base = ack_count;
        req_data = {8'h00, 8'h00, 8'h00, 8'hFF};
        sb.push_back(mk(0, 8, 1'b0));
        sb.push_back(mk(2, 0, 1'b0));
        req = 4'b0101;
        wait_drain("simultaneous", 200);
        compared++; if (ack_count - base !== 2) begin mismatched++; $display("FAIL simul_ack_count: got %0d want 2", ack_count - base); end
    endtask

    task automatic test_round_robin();
        int base;
        int exp_res[4] = '{2, 3, 3, 4};
        apply_reset();
        base = ack_count;
        req_data = {8'd23, 8'd22, 8'd21, 8'd20};
        for (int k = 0; k < 8; k++) sb.push_back(mk(k % 4, exp_res[k % 4], 1'b0));
        hold_left = 8;
        req = 4'b1111;
        wait_drain("round_robin", 600);
        compared++; if (ack_count - base !== 8) begin mismatched++; $display("FAIL rr_ack_count: got %0d want 8", ack_count - base); end
    endtask

    task automatic test_reset_mid_run();
        int  base;
        bit  seen = 1'b0;
        apply_reset();
        req_data = '0; req_data[7:0] = 8'hAA; req_data[15:8] = 8'h0F;
        sb.push_back(mk(0, 4, 1'b0));
        req = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cnt_start) begin seen = 1'b1; break; end
        end
        compared++; if (!seen) begin mismatched++; $display("FAIL midrun_start_seen: got 0 want 1"); end
        reset_n = 1'b0;
        #1;
        compared++;
        if ({ack, result, resp_id, err, busy, cnt_start, cnt_in} !== '0) begin
            mismatched++;
            $display("FAIL midrun_async_clear: ack=%b result=%0d id=%0d err=%b busy=%b start=%b in=%h want all 0",
                     ack, result, resp_id, err, busy, cnt_start, cnt_in);
        end
        sb.delete(); req = '0;
        base = ack_count;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        compared++; if (ack_count - base !== 0) begin mismatched++; $display("FAIL midrun_no_ack: got %0d want 0", ack_count - base); end
        sb.push_back(mk(1, 4, 1'b0));
        req = 4'b0010;
        wait_drain("after_reset", 100);
        compared++; if (ack_count - base !== 1) begin mismatched++; $display("FAIL after_reset_ack_count: got %0d want 1", ack_count - base); end
    endtask

`ifdef BIT_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        bit seen = 1'b0;
        apply_reset();
        stub_hang = 1'b1;
        req_data = '0; req_data[7:0] = 8'hFF;
        sb.push_back(mk(0, 0, 1'b1));
        req = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cnt_start) begin seen = 1'b1; break; end
        end
        for (int i = 0; i < 100 && seen; i++) begin
            @(negedge clk);
            n++;
            if (ack != '0) break;
        end
        compared++; if (n !== TMO) begin mismatched++; $display("FAIL timeout_latency: got %0d want %0d", n, TMO); end
        wait_drain("timeout", 50);
        stub_hang = 1'b0;
    endtask
`endif

    initial begin
        exp_t            e;
        logic [NUM_REQ-1:0] prev_ack  = '0;
        logic            prev_busy = 1'b0;
        logic [7:0]      prev_in   = 8'h00;
        logic [NUM_REQ-1:0] want_ack;
        req = '0; req_data = '0; reset_n = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (reset_n) begin
                    if (busy && prev_busy) begin
                        compared++;
                        if (cnt_in !== prev_in) begin mismatched++; $display("FAIL cnt_in_stable: got %h want %h", cnt_in, prev_in); end
                    end
                    if (busy && !prev_busy) begin
                        compared++;
                        if (cnt_start !== 1'b0) begin mismatched++; $display("FAIL start_in_load: got %b want 0", cnt_start); end
                    end
                    if (ack != '0) begin
                        ack_count++;
                        compared++;
                        if (!$onehot(ack) || prev_ack != '0) begin
                            mismatched++; $display("FAIL ack_shape: got %b (prev %b) want one-hot single pulse", ack, prev_ack);
                        end
                        compared++;
                        if (cnt_start !== 1'b0) begin mismatched++; $display("FAIL start_in_drain: got %b want 0", cnt_start); end
                        compared++;
                        if (sb.size() == 0) begin
                            mismatched++; $display("FAIL unexpected_ack: got ack=%b id=%0d want none", ack, resp_id);
                        end else begin
                            e = sb.pop_front();
                            want_ack = NUM_REQ'(1) << e.id;
                            if ({ack, resp_id, result, err} !== {want_ack, e.id, e.res, e.err}) begin
                                mismatched++;
                                $display("FAIL ack_payload: got ack=%b id=%0d result=%0d err=%b want ack=%b id=%0d result=%0d err=%b",
                                         ack, resp_id, result, err, want_ack, e.id, e.res, e.err);
                            end
                        end
                        if (hold_left > 0) begin
                            hold_left--;
                            if (hold_left == 0) req = '0;
                        end else begin
                            req = req & ~ack;
                        end
                    end
                end
                prev_ack = ack; prev_busy = busy; prev_in = cnt_in;
            end
        join_none

        test_reset();
        test_single_job();
        test_simultaneous();
        test_round_robin();
        test_reset_mid_run();
`ifdef BIT_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule

// File: doc/bit_count_scheduler.md
# bit_count_scheduler

Round-robin scheduler that shares one `bit_counter` datapath among `NUM_REQ` requesters. It arbitrates requests and sequences the counter's `start`/`done` handshake: load operand, run, capture result, release. It returns each requester a one-cycle acknowledge carrying the counted result. It sits between the synchronized request sources and the single `bit_counter` instance in the top level.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: requester index width.
- `TIMEOUT_CYCLES`, default 32: watchdog limit in RUN; only used with `BIT_SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  level request per requester; held until its `ack`.
- `req_data`  in  NUM_REQ*8  operand for requester i in bits [8i+7:8i]; stable while `req[i]` high.
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `result`  out  4  bit count for the acked requester; valid while `ack` high; held otherwise.
- `resp_id`  out  ID_W  index of the acked requester; valid with `ack`.
- `err`  out  1  high with `ack` when the job timed out.
- `busy`  out  1  high in every state except IDLE.
- `cnt_start`  out  1  to `bit_counter.start`.
- `cnt_in`  out  8  to `bit_counter.in`.
- `cnt_done`  in  1  from `bit_counter.done`.
- `cnt_result`  in  4  from `bit_counter.result`.

## Operation

- States: IDLE, LOAD, RUN, DRAIN. All outputs are registered.
- **IDLE** (`cnt_start`=0):
  - If any `req` is high, grant the first set bit searching from `last+1` modulo NUM_REQ.
  - Latch the grant index into `gnt_id`, drive `cnt_in` from that requester's `req_data`, then go to LOAD.
  - `last` updates to `gnt_id` at grant.
- **LOAD**, exactly one cycle:
  - `cnt_start`=0 and `cnt_in` stable, so the counter captures the operand in its idle state.
  - Go to RUN.
- **RUN**:
  - `cnt_start`=1.
  - When `cnt_done`=1 is sampled: latch `cnt_result` into `result`, pulse `ack[gnt_id]`, drive `resp_id`=`gnt_id`, `err`=0, go to DRAIN.
- **DRAIN**:
  - `cnt_start`=0.
  - Stay until `cnt_done`=0 is sampled, then go to IDLE.
- The scheduler does not sample `req` outside IDLE. The requester must drop `req` in the cycle after it sees `ack`. A `req` still high in IDLE counts as a new request.
- A `req` that drops before its grant is silently ignored.
- `cnt_in` is held at the granted operand from IDLE exit through DRAIN.
- `result` is zero-extended in width and equals the popcount of the operand, 0..8.

Reset (`reset_n`=0, asynchronous, any state):
- State goes to IDLE.
- `cnt_start`, `cnt_in`, `ack`, `result`, `resp_id`, `err`, `busy` all go to 0.
- `last` goes to NUM_REQ-1, so requester 0 has first priority.
- A job in flight is dropped without an `ack`.

## Timing

- Grant happens on the first IDLE edge where `req` is nonzero.
- LOAD follows one cycle later; RUN begins the cycle after that.
- The `ack` edge is one cycle after the edge where `cnt_done`=1 is sampled.
- Minimum IDLE-to-IDLE turnaround equals bit_counter latency + 4 cycles.
- Back-to-back grants are separated by at least one IDLE cycle.
- Fairness: under continuous full load each requester gets exactly one grant per NUM_REQ jobs, in ascending index order with wrap-around.

## Configuration

`BIT_SCHED_TIMEOUT_EN` defined:
- A counter clears on RUN entry and increments each RUN cycle.
- If it reaches `TIMEOUT_CYCLES` without `cnt_done`:
  - pulse `ack[gnt_id]` with `err`=1 and `result`=0;
  - go to DRAIN.
- In DRAIN, `cnt_done` already low exits to IDLE next cycle.

`BIT_SCHED_TIMEOUT_EN` undefined:
- No counter.
- `err` is tied 0.
- RUN waits for `cnt_done` indefinitely.

## Test plan

- **Single job:** `req`=0001, `req_data[7:0]`=0x16 → one `ack`=0001 pulse, `result`=3, `resp_id`=0, `err`=0, `busy` low afterwards.
- **Simultaneous requests:** `req`=0101 asserted together with operands 0xFF (id0) and 0x00 (id2) → id0 acked first with `result`=8, then id2 with `result`=0.
- **Round-robin wrap:** all four held continuously with operands 20..23 for 8 jobs → `resp_id` sequence 0,1,2,3,0,1,2,3 with `result` 2,3,3,4 repeating.
- **Reset mid-RUN:** drop `reset_n` while `cnt_start`=1 → all outputs 0 immediately with no `ack`; after release, `req`=0010 is granted normally.
- **Handshake check (bench assertions):**
  - `cnt_in` never changes while `busy`=1;
  - `cnt_start` is never 1 in LOAD or DRAIN;
  - `ack` is always one-hot or zero and lasts one cycle.
- **Timeout** (`BIT_SCHED_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=32): stub holds `cnt_done`=0 → `ack` with `err`=1, `result`=0, 32 cycles after RUN entry; the scheduler returns to IDLE.
